// File: rtl/instr_encoder_loader.sv
// ============================================================================
// Module  : instr_encoder_loader
// Brief   : Packs RV32I load/R/store/branch fields into 32-bit words and writes
//           them sequentially into an instruction-memory preload port.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_encoder_loader #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear_i,
  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic [1:0]    cmd_type_i,
  input  logic [4:0]    rd_i,
  input  logic [4:0]    rs1_i,
  input  logic [4:0]    rs2_i,
  input  logic [2:0]    funct3_i,
  input  logic [6:0]    funct7_i,
  input  logic [12:0]   imm_i,
  output logic          imem_we_o,
  output logic [AW-1:0] imem_addr_o,
  output logic [31:0]   imem_wdata_o,
  output logic [AW:0]   count_o,
  output logic          full_o,
  output logic          err_o
);

  localparam logic [6:0]  OP_LOAD   = 7'b0000011;
  localparam logic [6:0]  OP_R      = 7'b0110011;
  localparam logic [6:0]  OP_STORE  = 7'b0100011;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
  localparam logic [AW:0] FULL_CNT  = DEPTH[AW:0];

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_WRITE = 1'b1
  } state_t;

  state_t        state_q;
  logic [AW:0]   count_q;
  logic [AW:0]   count_inc;
  logic          full_q;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q;
  logic          err_q;
  logic [31:0]   enc_d;
  logic          illegal_d;
  logic          accept;

  // Load/store immediates must fit in 12 signed bits; branch offsets must be even.
  always_comb begin
    enc_d     = 32'h0;
    illegal_d = 1'b0;
    case (cmd_type_i)
      2'b00: begin
        enc_d     = {imm_i[11:0], rs1_i, funct3_i, rd_i, OP_LOAD};
        illegal_d = imm_i[12] ^ imm_i[11];
      end
      2'b01: begin
        enc_d     = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, OP_R};
      end
      2'b10: begin
        enc_d     = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], OP_STORE};
        illegal_d = imm_i[12] ^ imm_i[11];
      end
      default: begin
        enc_d     = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                     imm_i[4:1], imm_i[11], OP_BRANCH};
        illegal_d = imm_i[0];
      end
    endcase
  end

  assign cmd_ready_o = (state_q == S_IDLE) && !full_q && !clear_i;
  assign accept      = cmd_valid_i && cmd_ready_o;
  assign count_inc   = count_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      full_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else if (clear_i) begin
      // A write already on the port this cycle completes; only the pointer restarts.
      state_q <= S_IDLE;
      count_q <= '0;
      full_q  <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (illegal_d) begin
              err_q <= 1'b1;
            end else begin
              we_q    <= 1'b1;
              addr_q  <= count_q[AW-1:0];
              wdata_q <= enc_d;
              state_q <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          we_q    <= 1'b0;
          count_q <= count_inc;
          full_q  <= (count_inc == FULL_CNT);
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          we_q    <= 1'b0;
        end
      endcase
    end
  end

  assign imem_we_o    = we_q;
  assign imem_addr_o  = addr_q;
  assign imem_wdata_o = wdata_q;
  assign count_o      = count_q;
  assign full_o       = full_q;
  assign err_o        = err_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_encoder_loader.sv
// ============================================================================
// Module  : tb_instr_encoder_loader
// Brief   : Directed-vector bench for instr_encoder_loader.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_encoder_loader;

  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic          clk;
  logic          rst;
  logic          clear_i;
  logic          cmd_valid_i;
  logic          cmd_ready_o;
  logic [1:0]    cmd_type_i;
  logic [4:0]    rd_i;
  logic [4:0]    rs1_i;
  logic [4:0]    rs2_i;
  logic [2:0]    funct3_i;
  logic [6:0]    funct7_i;
  logic [12:0]   imm_i;
  logic          imem_we_o;
  logic [AW-1:0] imem_addr_o;
  logic [31:0]   imem_wdata_o;
  logic [AW:0]   count_o;
  logic          full_o;
  logic          err_o;

  instr_encoder_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (clear_i),
    .cmd_valid_i  (cmd_valid_i),
    .cmd_ready_o  (cmd_ready_o),
    .cmd_type_i   (cmd_type_i),
    .rd_i         (rd_i),
    .rs1_i        (rs1_i),
    .rs2_i        (rs2_i),
    .funct3_i     (funct3_i),
    .funct7_i     (funct7_i),
    .imm_i        (imm_i),
    .imem_we_o    (imem_we_o),
    .imem_addr_o  (imem_addr_o),
    .imem_wdata_o (imem_wdata_o),
    .count_o      (count_o),
    .full_o       (full_o),
    .err_o        (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Write/err monitor, sampled mid-cycle
  logic [31:0] wr_data[$];
  logic [5:0]  wr_addr[$];
  time         wr_time[$];
  int          err_cnt  = 0;
  int          both_cnt = 0;

  always @(negedge clk) begin
    if (imem_we_o) begin
      wr_data.push_back(imem_wdata_o);
      wr_addr.push_back(imem_addr_o);
      wr_time.push_back($time);
    end
    if (err_o) err_cnt++;
    if (err_o && imem_we_o) both_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_fields(input logic [1:0] t, input logic [4:0] rd, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                            input logic [12:0] imm);
    cmd_type_i = t;
    rd_i       = rd;
    rs1_i      = rs1;
    rs2_i      = rs2;
    funct3_i   = f3;
    funct7_i   = f7;
    imm_i      = imm;
  endtask

  // Returns 1 ns after the accepting edge.
  task automatic send(input logic [1:0] t, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [12:0] imm);
    int budget;
    budget = 0;
    @(negedge clk);
    set_fields(t, rd, rs1, rs2, f3, f7, imm);
    cmd_valid_i = 1'b1;
    while (!cmd_ready_o && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 50) begin
      chk("accept_timeout", 32'(budget), 32'd0);
      cmd_valid_i = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      cmd_valid_i = 1'b0;
    end
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear_i = 1'b1;
    @(posedge clk);
    #1;
    clear_i = 1'b0;
  endtask

  int q0;
  int e0;
  int bad;

  initial begin
    rst         = 1'b1;
    clear_i     = 1'b0;
    cmd_valid_i = 1'b0;
    set_fields(2'b00, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 13'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_count", 32'(count_o), 32'd0);
    chk("rst_we", 32'(imem_we_o), 32'd0);
    chk("rst_addr", 32'(imem_addr_o), 32'd0);
    chk("rst_wdata", imem_wdata_o, 32'h0);
    chk("rst_err", 32'(err_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_ready", 32'(cmd_ready_o), 32'd1);
    chk("rst_full", 32'(full_o), 32'd0);

    // 1: single load
    send(2'b00, 5'd5, 5'd2, 5'd0, 3'b010, 7'd0, 13'd8);
    chk("t1_we", 32'(imem_we_o), 32'd1);
    chk("t1_addr", 32'(imem_addr_o), 32'd0);
    chk("t1_wdata", imem_wdata_o, 32'h00812283);
    chk("t1_ready_in_write", 32'(cmd_ready_o), 32'd0);
    @(posedge clk);
    #1;
    chk("t1_count", 32'(count_o), 32'd1);
    chk("t1_we_drop", 32'(imem_we_o), 32'd0);

    // 2: R then store, back to back
    do_clear();
    wr_data.delete(); wr_addr.delete(); wr_time.delete();
    send(2'b01, 5'd3, 5'd1, 5'd2, 3'b000, 7'd0, 13'd0);
    send(2'b10, 5'd0, 5'd2, 5'd6, 3'b010, 7'd0, 13'd12);
    repeat (2) @(posedge clk);
    #1;
    chk("t2_nwrites", 32'(wr_data.size()), 32'd2);
    if (wr_data.size() == 2) begin
      chk("t2_addr0", 32'(wr_addr[0]), 32'd0);
      chk("t2_data0", wr_data[0], 32'h002081B3);
      chk("t2_addr1", 32'(wr_addr[1]), 32'd1);
      chk("t2_data1", wr_data[1], 32'h00612623);
      chk("t2_spacing", 32'(wr_time[1] - wr_time[0]), 32'd20);
    end
    chk("t2_count", 32'(count_o), 32'd2);

    // 3 plus immediate boundaries
    send(2'b11, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 13'h1FFC);
    chk("t3_branch_m4", imem_wdata_o, 32'hFE208EE3);
    send(2'b00, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 13'h1800);
    chk("load_m2048", imem_wdata_o, 32'h80000083);
    send(2'b10, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, 13'h07FF);
    chk("store_2047", imem_wdata_o, 32'h7E000FA3);
    send(2'b11, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, 13'h0FFE);
    chk("branch_4094", imem_wdata_o, 32'h7E000FE3);
    chk("boundary_addr", 32'(imem_addr_o), 32'd5);
    @(posedge clk);
    #1;

    // 4: illegal immediates
    q0 = wr_data.size();
    e0 = err_cnt;
    send(2'b11, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 13'h0003);
    chk("t4_err_a", 32'(err_o), 32'd1);
    chk("t4_we_a", 32'(imem_we_o), 32'd0);
    send(2'b00, 5'd5, 5'd2, 5'd0, 3'b010, 7'd0, 13'h0800);
    chk("t4_err_b", 32'(err_o), 32'd1);
    @(posedge clk);
    #1;
    chk("t4_err_drop", 32'(err_o), 32'd0);
    chk("t4_err_pulses", 32'(err_cnt - e0), 32'd2);
    chk("t4_no_write", 32'(wr_data.size() - q0), 32'd0);
    chk("t4_count", 32'(count_o), 32'd6);

    // 5: fill to DEPTH
    do_clear();
    chk("t5_clear_count", 32'(count_o), 32'd0);
    wr_data.delete(); wr_addr.delete(); wr_time.delete();
    for (int i = 0; i < DEPTH; i++) begin
      send(2'b01, 5'(i), 5'd1, 5'd2, 3'b000, 7'd0, 13'd0);
    end
    @(posedge clk);
    #1;
    chk("t5_count", 32'(count_o), 32'd64);
    chk("t5_full", 32'(full_o), 32'd1);
    chk("t5_ready", 32'(cmd_ready_o), 32'd0);
    bad = 0;
    for (int i = 0; i < wr_addr.size(); i++) if (wr_addr[i] != 6'(i)) bad++;
    chk("t5_seq_addr", 32'(bad), 32'd0);
    chk("t5_nwrites", 32'(wr_data.size()), 32'd64);
    q0 = wr_data.size();
    @(negedge clk);
    set_fields(2'b00, 5'd5, 5'd2, 5'd0, 3'b010, 7'd0, 13'd8);
    cmd_valid_i = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("t5_extra_ignored", 32'(wr_data.size() - q0), 32'd0);
    chk("t5_count_hold", 32'(count_o), 32'd64);
    @(negedge clk);
    clear_i = 1'b1;
    #1;
    chk("t5_clr_ready", 32'(cmd_ready_o), 32'd0);
    @(posedge clk);
    #1;
    chk("t5_clr_no_accept", 32'(imem_we_o), 32'd0);
    chk("t5_clr_count", 32'(count_o), 32'd0);
    chk("t5_clr_full", 32'(full_o), 32'd0);
    @(negedge clk);
    clear_i     = 1'b0;
    cmd_valid_i = 1'b0;
    send(2'b00, 5'd5, 5'd2, 5'd0, 3'b010, 7'd0, 13'd8);
    chk("t5_readdr", 32'(imem_addr_o), 32'd0);
    chk("t5_rewdata", imem_wdata_o, 32'h00812283);
    @(posedge clk);
    #1;

    // clear during WRITE: pending write completes, pointer restarts
    send(2'b01, 5'd3, 5'd1, 5'd2, 3'b000, 7'd0, 13'd0);
    chk("clrw_addr", 32'(imem_addr_o), 32'd1);
    clear_i = 1'b1;
    q0 = wr_data.size();
    @(posedge clk);
    #1;
    clear_i = 1'b0;
    chk("clrw_write_done", 32'(wr_data.size() - q0), 32'd1);
    chk("clrw_count", 32'(count_o), 32'd0);
    chk("clrw_we", 32'(imem_we_o), 32'd0);

    // 6: rst during WRITE
    send(2'b00, 5'd5, 5'd2, 5'd0, 3'b010, 7'd0, 13'd8);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_we", 32'(imem_we_o), 32'd0);
    chk("t6_count", 32'(count_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t6_ready", 32'(cmd_ready_o), 32'd1);
    @(posedge clk);
    #1;
    chk("t6_we_stays", 32'(imem_we_o), 32'd0);

    chk("err_we_exclusive", 32'(both_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
